// File: rtl/ex_muldiv_unit_if.sv
// Purpose: handshake/bus bundle between the EX stage and the iterative mul/div unit.
// Latency: none (wires only).
// Backpressure: stall_in from downstream, stall_req back to the front end.
// Ports (master = EX stage side, slave = mul/div unit side):
//   start, op, src_a, src_b, flush, stall_in  : EX stage -> unit
//   stall_req, busy, result_valid, result      : unit -> EX stage
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            stall_in;
  logic            stall_req;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, src_a, src_b, flush, stall_in,
    input  stall_req, busy, result_valid, result
  );

  modport slave (
    input  start, op, src_a, src_b, flush, stall_in,
    output stall_req, busy, result_valid, result
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Purpose: iterative RV32M multiply/divide (shift-add multiplier, restoring divider) in EX.
// Latency: result_valid XLEN+2 cycles after start is accepted; 1 cycle for div-by-zero/overflow.
// Backpressure: stall_req freezes the front end while working; result held in DONE while stall_in.
// Ports: clk, rst (sync, active-high); mdu (slave modport of ex_muldiv_unit_if):
//   start/op/src_a/src_b request, flush kill, stall_in hold, stall_req/busy/result_valid/result out.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  ex_muldiv_unit_if.slave mdu
);
  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  logic [1:0]        state;
  logic [2:0]        op_r;
  logic [2*XLEN-1:0] mag_a;    // multiplicand (shifts left) / dividend (low half, shifts left)
  logic [XLEN-1:0]   mag_b;    // multiplier (shifts right) / divisor (static)
  logic [2*XLEN-1:0] acc;      // product, or {remainder, quotient} for divide
  logic [CW-1:0]     count;
  logic              neg_res;
  logic [XLEN-1:0]   result_r;

  // Operand conditioning for the op currently presented in IDLE.
  logic            a_sgn, b_sgn, a_neg, b_neg, neg_next;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            special;
  logic [XLEN-1:0] special_val;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (mdu.op)
      3'd0, 3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'd2:                   begin a_sgn = 1'b1; b_sgn = 1'b0; end
      default:                begin a_sgn = 1'b0; b_sgn = 1'b0; end
    endcase
    a_neg = a_sgn & mdu.src_a[XLEN-1];
    b_neg = b_sgn & mdu.src_b[XLEN-1];
    abs_a = a_neg ? -mdu.src_a : mdu.src_a;
    abs_b = b_neg ? -mdu.src_b : mdu.src_b;
    // Remainder takes the dividend's sign; everything else takes the product of signs.
    neg_next = (mdu.op[2] && mdu.op[1]) ? a_neg : (a_neg ^ b_neg);

    special     = 1'b0;
    special_val = '0;
    if (mdu.op[2] && mdu.src_b == '0) begin
      special     = 1'b1;
      special_val = mdu.op[1] ? mdu.src_a : ALL_ONE;
    end else if ((mdu.op == 3'd4 || mdu.op == 3'd6) &&
                 mdu.src_a == INT_MIN && mdu.src_b == ALL_ONE) begin
      special     = 1'b1;
      special_val = mdu.op[1] ? '0 : INT_MIN;
    end
  end

  // One restoring-division step: bring the next dividend bit into the partial remainder.
  logic [XLEN:0]   rem_sh;
  logic            no_borrow;
  logic [XLEN-1:0] rem_next;

  always_comb begin
    rem_sh    = {acc[2*XLEN-1:XLEN], mag_a[XLEN-1]};
    no_borrow = (rem_sh >= {1'b0, mag_b});
    // The true difference is below the divisor, so the low XLEN bits are exact.
    rem_next  = no_borrow ? (rem_sh[XLEN-1:0] - mag_b) : rem_sh[XLEN-1:0];
  end

  // Output selection with sign fix-up applied before picking the half.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_val;

  always_comb begin
    prod_s = neg_res ? -acc : acc;
    quo_s  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s  = neg_res ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_r)
      3'd0:       fix_val = prod_s[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       fix_val = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5: fix_val = quo_s;
      default:    fix_val = rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_r     <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      count    <= '0;
      neg_res  <= 1'b0;
      result_r <= '0;
    end else if (mdu.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (mdu.start) begin
            op_r    <= mdu.op;
            mag_a   <= {{XLEN{1'b0}}, abs_a};
            mag_b   <= abs_b;
            neg_res <= neg_next;
            acc     <= '0;
            count   <= '0;
            if (special) begin
              result_r <= special_val;
              state    <= S_DONE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          count <= count + 1'b1;
          if (op_r[2]) begin
            acc   <= {rem_next, acc[XLEN-2:0], no_borrow};
            mag_a <= {mag_a[2*XLEN-2:0], 1'b0};
          end else begin
            if (mag_b[0]) acc <= acc + mag_a;
            mag_a <= {mag_a[2*XLEN-2:0], 1'b0};
            mag_b <= {1'b0, mag_b[XLEN-1:1]};
          end
          if (count == CW'(XLEN-1)) state <= S_FIX;
        end
        S_FIX: begin
          result_r <= fix_val;
          state    <= S_DONE;
        end
        default: begin
          // start stays high here for the same instruction, so it is not looked at.
          if (!mdu.stall_in) state <= S_IDLE;
        end
      endcase
    end
  end

  assign mdu.stall_req    = (state == S_IDLE && mdu.start && !mdu.flush) ||
                            state == S_RUN || state == S_FIX;
  assign mdu.busy         = (state != S_IDLE);
  assign mdu.result_valid = (state == S_DONE);
  assign mdu.result       = result_r;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Purpose: directed self-checking bench for ex_muldiv_unit (all 8 ops, specials, stall, flush, reset).
// Latency: checks result_valid cycle against hand-computed latencies.
// Backpressure: exercises stall_in hold in DONE and flush/reset mid-operation.
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic rst;

  ex_muldiv_unit_if #(.XLEN(32)) mif ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a posedge with the unit idle. Holds start until the result is
  // consumed (stall_in low), as the pipeline would.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int cyc;
    int stall_err;
    bit seen;
    cyc = 0; stall_err = 0; seen = 0;
    mif.start = 1'b1; mif.op = o; mif.src_a = a; mif.src_b = b;
    #1;
    if (!mif.stall_req) stall_err++;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (mif.result_valid) seen = 1;
      else if (!mif.stall_req) stall_err++;
    end
    check({tag, ".lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, ".res"}, {32'h0, mif.result}, {32'h0, exp});
    check({tag, ".stall"}, 64'(stall_err), 64'd0);
    check({tag, ".stall_done"}, {63'h0, mif.stall_req}, 64'd0);
    @(posedge clk); #1;
    mif.start = 1'b0;
    #1;
    check({tag, ".idle"}, {62'h0, mif.busy, mif.result_valid}, 64'd0);
  endtask

  initial begin
    int cyc;
    int hold_err;
    rst = 1'b1;
    mif.start = 1'b0; mif.op = 3'd0; mif.src_a = '0; mif.src_b = '0;
    mif.flush = 1'b0; mif.stall_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", {63'h0, mif.result_valid}, 64'd0);
    check("reset.busy", {63'h0, mif.busy}, 64'd0);
    check("reset.stall_req", {63'h0, mif.stall_req}, 64'd0);
    check("reset.result", {32'h0, mif.result}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulh_min",     3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    run_op("divu_100_7",   3'd5, 32'd100,        32'd7,         32'd14,        34);
    run_op("remu_100_7",   3'd7, 32'd100,        32'd7,         32'd2,         34);
    run_op("div_by0",      3'd4, 32'd9,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_5_0",      3'd6, 32'd5,          32'd0,         32'd5,         1);
    run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

    // DIVU 100/7 with downstream stalled: result must be held in DONE.
    mif.stall_in = 1'b1;
    mif.start = 1'b1; mif.op = 3'd5; mif.src_a = 32'd100; mif.src_b = 32'd7;
    cyc = 0;
    while (!mif.result_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stall.lat", 64'(cyc), 64'd34);
    check("stall.res", {32'h0, mif.result}, 64'd14);
    hold_err = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!mif.result_valid || !mif.busy || mif.stall_req || mif.result !== 32'd14) hold_err++;
    end
    check("stall.hold", 64'(hold_err), 64'd0);
    mif.stall_in = 1'b0;
    @(posedge clk); #1;
    mif.start = 1'b0;
    #1;
    check("stall.release", {62'h0, mif.busy, mif.result_valid}, 64'd0);

    // Flush at RUN count 10 (cycle 11 after acceptance).
    mif.start = 1'b1; mif.op = 3'd0; mif.src_a = 32'd3; mif.src_b = 32'd5;
    repeat (11) begin
      @(posedge clk); #1;
    end
    check("flush.busy_before", {63'h0, mif.busy}, 64'd1);
    mif.flush = 1'b1;
    @(posedge clk); #1;
    mif.flush = 1'b0; mif.start = 1'b0;
    #1;
    check("flush.state", {61'h0, mif.busy, mif.result_valid, mif.stall_req}, 64'd0);
    check("flush.result_kept", {32'h0, mif.result}, 64'd14);
    @(posedge clk); #1;
    run_op("divu_after_flush", 3'd5, 32'd1000, 32'd10, 32'd100, 34);

    // Reset at RUN count 5 (cycle 6 after acceptance).
    mif.start = 1'b1; mif.op = 3'd0; mif.src_a = 32'd3; mif.src_b = 32'd4;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; mif.start = 1'b0;
    @(posedge clk); #1;
    check("rst_mid.ctrl", {61'h0, mif.busy, mif.result_valid, mif.stall_req}, 64'd0);
    check("rst_mid.result", {32'h0, mif.result}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
